// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared widths, load encodings and bus layout for the writeback stage
package wb_stage_pkg;

    localparam int Xlen              = 32;
    localparam int MemToWbWidth      = 204;
    localparam int RegsWriteBusWidth = 38;
    localparam int WbToCsrWidth      = 160;
    localparam int WbFwdWidth        = 39;

    // Field offsets (LSB position) inside mem_to_wb_bus
    localparam int OffAddrLo   = 0;
    localparam int OffLdType   = 2;
    localparam int OffLdEn     = 5;
    localparam int OffBadv     = 6;
    localparam int OffErtn     = 38;
    localparam int OffEsubcode = 39;
    localparam int OffEcode    = 48;
    localparam int OffExcp     = 54;
    localparam int OffCsrWdata = 55;
    localparam int OffCsrWmask = 87;
    localparam int OffCsrNum   = 119;
    localparam int OffCsrWe    = 133;
    localparam int OffRfWdata  = 134;
    localparam int OffRfWaddr  = 166;
    localparam int OffRfWe     = 171;
    localparam int OffPc       = 172;

    typedef enum logic [2:0] {
        LD_B  = 3'd0,
        LD_H  = 3'd1,
        LD_W  = 3'd2,
        LD_BU = 3'd4,
        LD_HU = 3'd5
    } ld_type_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EXEC      = 2'd1,
        WAIT_DATA = 2'd2
    } wb_state_e;

    // Packed in the same order as the MEM->WB concatenation (first field is MSB)
    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
        logic        excp;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        ertn;
        logic [31:0] badv;
        logic        ld_en;
        logic [2:0]  ld_type;
        logic [1:0]  addr_lo;
    } mem_to_wb_t;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - byte/half selection and sign/zero extension of a raw load word
module wb_load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr_lo,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // pick the addressed byte/half, then extend according to the load type
    always_comb begin
        byte_sel = raw[7:0];
        case (addr_lo)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
        case (ld_type_e'(ld_type))
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_BU:   result = {24'd0, byte_sel};
            LD_HU:   result = {16'd0, half_sel};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: MEM->WB register, load wait, regfile/CSR commit
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int MEM_WB_W = MemToWbWidth,
    parameter int XLEN     = Xlen
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_to_wb_valid,
    input  logic [MEM_WB_W-1:0]          mem_to_wb_bus,
    output logic                         wb_allowin,
    input  logic                         data_ok,
    input  logic [XLEN-1:0]              data_rdata,
    output logic [RegsWriteBusWidth-1:0] wb_to_regs_obus,
    output logic [WbToCsrWidth-1:0]      wb_to_csr_obus,
    output logic [WbFwdWidth-1:0]        wb_fwd_obus,
    output logic                         wb_flush,
    output logic [XLEN-1:0]              debug_wb_pc,
    output logic [3:0]                   debug_wb_rf_we,
    output logic [4:0]                   debug_wb_rf_wnum,
    output logic [XLEN-1:0]              debug_wb_rf_wdata
);

    mem_to_wb_t in_bus;
    mem_to_wb_t r;
    wb_state_e  state;
    logic       wb_valid;
    logic       ld_buf_v;
    logic [XLEN-1:0] ld_buf;

    logic ready_go, commit, capture, pending, early_data;
    logic excp_flush, ertn_flush, rf_commit;
    logic [XLEN-1:0] ld_raw, ld_result, rf_wdata;

    assign in_bus = mem_to_wb_t'(mem_to_wb_bus);

    // WAIT_DATA means the held load still owns the next data_ok
    assign pending    = (state == WAIT_DATA);
    assign ready_go   = !r.ld_en | r.excp | ld_buf_v | data_ok;
    assign commit     = wb_valid & ready_go;
    assign excp_flush = commit & r.excp;
    assign ertn_flush = commit & r.ertn & !r.excp;
    assign wb_flush   = excp_flush | ertn_flush;
    // The instruction sitting in MEM during a flush is dropped, not captured
    assign wb_allowin = (!wb_valid | ready_go) & !wb_flush;
    assign capture    = mem_to_wb_valid & wb_allowin;
    // data_ok seen alongside an incoming load belongs to it only if nothing older is waiting
    assign early_data = capture & in_bus.ld_en & !in_bus.excp & data_ok & !pending;

    // pipeline register, load buffer and FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            ld_buf_v <= 1'b0;
            ld_buf   <= '0;
            r        <= '0;
        end else if (capture) begin
            r        <= in_bus;
            wb_valid <= 1'b1;
            if (early_data) begin
                ld_buf   <= data_rdata;
                ld_buf_v <= 1'b1;
                state    <= EXEC;
            end else begin
                ld_buf_v <= 1'b0;
                state    <= (in_bus.ld_en & !in_bus.excp) ? WAIT_DATA : EXEC;
            end
        end else if (ready_go) begin
            wb_valid <= 1'b0;
            ld_buf_v <= 1'b0;
            state    <= IDLE;
        end
    end

    assign ld_raw = ld_buf_v ? ld_buf : data_rdata;

    wb_load_align u_align (
        .raw     (ld_raw),
        .ld_type (r.ld_type),
        .addr_lo (r.addr_lo),
        .result  (ld_result)
    );

    assign rf_commit = commit & r.rf_we & !r.excp;
    assign rf_wdata  = r.ld_en ? ld_result : r.rf_wdata;

    assign wb_to_regs_obus = rf_commit ? {1'b1, r.rf_waddr, rf_wdata} : '0;
    assign wb_fwd_obus     = {wb_valid & r.ld_en & !ready_go, wb_to_regs_obus};
    assign wb_to_csr_obus  = commit ? {r.csr_we & !r.excp, r.csr_num, r.csr_wmask, r.csr_wdata,
                                       excp_flush, ertn_flush, r.ecode, r.esubcode, r.pc, r.badv}
                                    : '0;

    assign debug_wb_pc       = rf_commit ? r.pc : '0;
    assign debug_wb_rf_we    = {4{rf_commit}};
    assign debug_wb_rf_wnum  = rf_commit ? r.rf_waddr : 5'd0;
    assign debug_wb_rf_wdata = rf_commit ? rf_wdata : '0;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
        logic        excp;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        ertn;
        logic [31:0] badv;
        logic        ld_en;
        logic [2:0]  ld_type;
        logic [1:0]  addr_lo;
    } ins_t;

    typedef struct packed {
        ins_t        ins;
        logic [3:0]  dly;
        logic [31:0] rdata;
        logic        e_we;
        logic [31:0] e_wdata;
        logic        e_ef;
        logic        e_rf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_to_wb_valid;
    logic [203:0] mem_to_wb_bus;
    logic         wb_allowin;
    logic         data_ok;
    logic [31:0]  data_rdata;
    logic [37:0]  wb_to_regs_obus;
    logic [159:0] wb_to_csr_obus;
    logic [38:0]  wb_fwd_obus;
    logic         wb_flush;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_we;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    wb_stage dut (
        .clk               (clk),
        .rst               (rst),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .wb_allowin        (wb_allowin),
        .data_ok           (data_ok),
        .data_rdata        (data_rdata),
        .wb_to_regs_obus   (wb_to_regs_obus),
        .wb_to_csr_obus    (wb_to_csr_obus),
        .wb_fwd_obus       (wb_fwd_obus),
        .wb_flush          (wb_flush),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic [31:0] pc, input logic rf_we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic excp, input logic [5:0] ecode,
                                input logic ertn, input logic ld_en, input logic [2:0] lt,
                                input logic [1:0] al);
        ins_t i;
        i = '0;
        i.pc = pc; i.rf_we = rf_we; i.waddr = wa; i.wdata = wd;
        i.csr_we = 1'b1; i.csr_num = 14'h0006; i.csr_wmask = 32'hFFFF_FFFF;
        i.csr_wdata = 32'hC5C5_0000 | pc; i.excp = excp; i.ecode = ecode;
        i.esubcode = 9'h001; i.ertn = ertn; i.badv = pc ^ 32'hFFFF_0000;
        i.ld_en = ld_en; i.ld_type = lt; i.addr_lo = al;
        return i;
    endfunction

    function automatic vec_t mkv(input ins_t i, input logic [3:0] dly, input logic [31:0] rd,
                                 input logic we, input logic [31:0] wd, input logic ef, input logic rf);
        vec_t v;
        v.ins = i; v.dly = dly; v.rdata = rd; v.e_we = we; v.e_wdata = wd; v.e_ef = ef; v.e_rf = rf;
        return v;
    endfunction

    // Reference load extraction written as plain arithmetic on the word
    function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] lt, input logic [1:0] al);
        logic [31:0] b, h;
        b = (w >> (8 * al)) & 32'hFF;
        h = (w >> (16 * al[1])) & 32'hFFFF;
        case (lt)
            3'd0:    return (b < 128) ? b : b + 32'hFFFF_FF00;
            3'd1:    return (h < 32768) ? h : h + 32'hFFFF_0000;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i;
        i.pc = $urandom; i.rf_we = ($urandom_range(0, 3) != 0); i.waddr = 5'($urandom);
        i.wdata = $urandom; i.csr_we = 1'($urandom_range(0, 1)); i.csr_num = 14'($urandom);
        i.csr_wmask = $urandom; i.csr_wdata = $urandom; i.excp = ($urandom_range(0, 7) == 0);
        i.ecode = 6'($urandom); i.esubcode = 9'($urandom); i.ertn = ($urandom_range(0, 7) == 0);
        i.badv = $urandom; i.ld_en = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0:       begin i.ld_type = 3'd0; i.addr_lo = 2'($urandom); end
            1:       begin i.ld_type = 3'd1; i.addr_lo = 2'($urandom_range(0, 1) * 2); end
            2:       begin i.ld_type = 3'd2; i.addr_lo = 2'd0; end
            3:       begin i.ld_type = 3'd4; i.addr_lo = 2'($urandom); end
            default: begin i.ld_type = 3'd5; i.addr_lo = 2'($urandom_range(0, 1) * 2); end
        endcase
        return i;
    endfunction

    task automatic do_reset();
        rst = 1'b1; mem_to_wb_valid = 1'b0; data_ok = 1'b0; data_rdata = '0; mem_to_wb_bus = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_regs"}, 160'(wb_to_regs_obus), 160'd0);
        check({nm, "_csr"}, wb_to_csr_obus, 160'd0);
        check({nm, "_fwd"}, 160'(wb_fwd_obus), 160'd0);
        check({nm, "_flush"}, 160'(wb_flush), 160'd0);
        check({nm, "_dbg"}, 160'({debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}), 160'd0);
        check({nm, "_allowin"}, 160'(wb_allowin), 160'd1);
    endtask

    vec_t vecs[13];

    // model state for the random phase
    logic        m_valid, m_have;
    ins_t        m_ins;
    logic [31:0] m_word;

    initial begin
        localparam logic [31:0] PC = 32'h1C00_0100;
        vecs[0]  = mkv(mk(PC,      1, 5'd5, 32'h1234, 0, 0, 0, 0, 3'd0, 2'd0), 0, 0,            1, 32'h0000_1234, 0, 0);
        vecs[1]  = mkv(mk(PC + 4,  1, 5'd6, 0,        0, 0, 0, 1, 3'd0, 2'd3), 3, 32'h80FF_FFFF, 1, 32'hFFFF_FF80, 0, 0);
        vecs[2]  = mkv(mk(PC + 8,  1, 5'd6, 0,        0, 0, 0, 1, 3'd4, 2'd3), 3, 32'h80FF_FFFF, 1, 32'h0000_0080, 0, 0);
        vecs[3]  = mkv(mk(PC + 12, 1, 5'd7, 0,        0, 0, 0, 1, 3'd1, 2'd2), 0, 32'h7FFF_0000, 1, 32'h0000_7FFF, 0, 0);
        vecs[4]  = mkv(mk(PC + 16, 1, 5'd8, 0,        0, 0, 0, 1, 3'd5, 2'd0), 1, 32'h1234_ABCD, 1, 32'h0000_ABCD, 0, 0);
        vecs[5]  = mkv(mk(PC + 20, 1, 5'd9, 0,        0, 0, 0, 1, 3'd2, 2'd0), 2, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0, 0);
        vecs[6]  = mkv(mk(PC + 24, 1, 5'd10, 0,       0, 0, 0, 1, 3'd0, 2'd1), 1, 32'h0000_7F00, 1, 32'h0000_007F, 0, 0);
        vecs[7]  = mkv(mk(PC + 28, 1, 5'd11, 0,       0, 0, 0, 1, 3'd1, 2'd0), 2, 32'h0000_8001, 1, 32'hFFFF_8001, 0, 0);
        vecs[8]  = mkv(mk(PC + 32, 1, 5'd12, 32'h99,  1, 6'h0B, 0, 0, 3'd0, 2'd0), 0, 0,     0, 0, 1, 0);
        vecs[9]  = mkv(mk(PC + 36, 0, 5'd0, 0,        0, 0, 1, 0, 3'd0, 2'd0), 0, 0,         0, 0, 0, 1);
        vecs[10] = mkv(mk(PC + 40, 0, 5'd0, 0,        1, 6'h08, 1, 0, 3'd0, 2'd0), 0, 0,     0, 0, 1, 0);
        vecs[11] = mkv(mk(PC + 44, 1, 5'd0, 32'h55,   0, 0, 0, 0, 3'd0, 2'd0), 0, 0,         1, 32'h0000_0055, 0, 0);
        vecs[12] = mkv(mk(PC + 48, 1, 5'd13, 0,       1, 6'h09, 0, 1, 3'd2, 2'd0), 5, 0,     0, 0, 1, 0);

        do_reset();
        #1 check_quiet("reset");

        // table: capture one instruction, deliver data after dly cycles, check the commit
        for (int v = 0; v < 13; v++) begin
            ins_t in;
            logic is_wait;
            int kc;
            in = vecs[v].ins;
            is_wait = in.ld_en && !in.excp;
            kc = (is_wait && vecs[v].dly != 0) ? int'(vecs[v].dly) : 1;
            @(negedge clk);
            mem_to_wb_valid = 1'b1; mem_to_wb_bus = in;
            data_ok = is_wait && (vecs[v].dly == 0);
            data_rdata = data_ok ? vecs[v].rdata : 32'h0BAD_0BAD;
            #1 check($sformatf("v%0d_allowin_cap", v), 160'(wb_allowin), 160'd1);
            for (int k = 1; k <= kc; k++) begin
                @(negedge clk);
                mem_to_wb_valid = 1'b0; mem_to_wb_bus = '0;
                data_ok = is_wait && (k == int'(vecs[v].dly));
                data_rdata = data_ok ? vecs[v].rdata : 32'h0BAD_0BAD;
                #1;
                if (k < kc) begin
                    check($sformatf("v%0d_busy_k%0d", v, k), 160'(wb_fwd_obus[38]), 160'd1);
                    check($sformatf("v%0d_nowe_k%0d", v, k), 160'(wb_to_regs_obus[37]), 160'd0);
                end else begin
                    check($sformatf("v%0d_regs", v), 160'(wb_to_regs_obus),
                          160'({vecs[v].e_we, vecs[v].e_we ? in.waddr : 5'd0,
                                vecs[v].e_we ? vecs[v].e_wdata : 32'd0}));
                    check($sformatf("v%0d_flushbits", v), 160'({wb_to_csr_obus[80], wb_to_csr_obus[79]}),
                          160'({vecs[v].e_ef, vecs[v].e_rf}));
                    check($sformatf("v%0d_csr_we", v), 160'(wb_to_csr_obus[159]), 160'(!in.excp));
                    check($sformatf("v%0d_wb_flush", v), 160'(wb_flush), 160'(vecs[v].e_ef | vecs[v].e_rf));
                    check($sformatf("v%0d_allowin", v), 160'(wb_allowin), 160'(!(vecs[v].e_ef | vecs[v].e_rf)));
                    check($sformatf("v%0d_dbg", v), 160'({debug_wb_rf_we, debug_wb_pc}),
                          160'({vecs[v].e_we ? 4'hF : 4'h0, vecs[v].e_we ? in.pc : 32'd0}));
                end
            end
            @(negedge clk);
            data_ok = 1'b0;
            #1 check($sformatf("v%0d_after_flush", v), 160'(wb_flush), 160'd0);
            check($sformatf("v%0d_after_regs", v), 160'(wb_to_regs_obus), 160'd0);
        end

        // exception in WB drops the instruction waiting in MEM
        @(negedge clk);
        mem_to_wb_valid = 1'b1; mem_to_wb_bus = mk(32'h200, 1, 5'd3, 32'h33, 1, 6'h0B, 0, 0, 3'd0, 2'd0);
        @(negedge clk);
        mem_to_wb_bus = mk(32'h204, 1, 5'd7, 32'h77, 0, 0, 0, 0, 3'd0, 2'd0);
        #1 check("drop_flush", 160'(wb_flush), 160'd1);
        check("drop_allowin", 160'(wb_allowin), 160'd0);
        @(negedge clk);
        mem_to_wb_valid = 1'b0;
        #1 check("drop_noregs", 160'(wb_to_regs_obus), 160'd0);
        check("drop_flush_off", 160'(wb_flush), 160'd0);

        // a stray data_ok while idle must not satisfy the next load
        @(negedge clk);
        data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        data_ok = 1'b0; mem_to_wb_valid = 1'b1;
        mem_to_wb_bus = mk(32'h300, 1, 5'd9, 0, 0, 0, 0, 1, 3'd2, 2'd0);
        @(negedge clk);
        mem_to_wb_valid = 1'b0;
        #1 check("stray_busy", 160'(wb_fwd_obus[38]), 160'd1);
        @(negedge clk);
        data_ok = 1'b1; data_rdata = 32'h1357_9BDF;
        #1 check("stray_commit", 160'(wb_to_regs_obus), 160'({1'b1, 5'd9, 32'h1357_9BDF}));
        @(negedge clk);
        data_ok = 1'b0;

        // reset while waiting for load data, then a late data_ok
        mem_to_wb_valid = 1'b1; mem_to_wb_bus = mk(32'h400, 1, 5'd4, 0, 0, 0, 0, 1, 3'd2, 2'd0);
        @(negedge clk);
        mem_to_wb_valid = 1'b0;
        #1 check("rstwait_busy", 160'(wb_fwd_obus[38]), 160'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; data_ok = 1'b1; data_rdata = 32'hAAAA_5555;
        #1 check_quiet("rstwait");
        @(negedge clk);
        data_ok = 1'b0;
        #1 check_quiet("rstwait_late");

        // randomized traffic against the transaction model
        do_reset();
        m_valid = 1'b0; m_have = 1'b0; m_ins = '0; m_word = '0;
        for (int c = 0; c < 800; c++) begin
            ins_t nx;
            logic need, go, cm, rf, ef, erf, allow, busy;
            logic [31:0] wd;
            logic [37:0] e_regs;
            logic [159:0] e_csr;
            @(negedge clk);
            nx = rnd_ins();
            mem_to_wb_valid = ($urandom_range(0, 3) != 0);
            mem_to_wb_bus = nx;
            data_ok = ($urandom_range(0, 2) == 0);
            data_rdata = $urandom;
            #1;
            need  = m_valid && m_ins.ld_en && !m_ins.excp && !m_have;
            go    = !need || data_ok;
            cm    = m_valid && go;
            ef    = cm && m_ins.excp;
            erf   = cm && m_ins.ertn && !m_ins.excp;
            allow = (!m_valid || go) && !(ef || erf);
            busy  = m_valid && need && !data_ok;
            rf    = cm && m_ins.rf_we && !m_ins.excp;
            wd    = m_ins.ld_en ? ld_ext(m_have ? m_word : data_rdata, m_ins.ld_type, m_ins.addr_lo) : m_ins.wdata;
            e_regs = rf ? {1'b1, m_ins.waddr, wd} : 38'd0;
            e_csr  = cm ? {m_ins.csr_we && !m_ins.excp, m_ins.csr_num, m_ins.csr_wmask, m_ins.csr_wdata,
                           ef, erf, m_ins.ecode, m_ins.esubcode, m_ins.pc, m_ins.badv} : 160'd0;
            check($sformatf("rnd%0d_allowin", c), 160'(wb_allowin), 160'(allow));
            check($sformatf("rnd%0d_regs", c), 160'(wb_to_regs_obus), 160'(e_regs));
            check($sformatf("rnd%0d_csr", c), wb_to_csr_obus, e_csr);
            check($sformatf("rnd%0d_fwd", c), 160'(wb_fwd_obus), 160'({busy, e_regs}));
            check($sformatf("rnd%0d_flush", c), 160'(wb_flush), 160'(ef || erf));
            check($sformatf("rnd%0d_dbg", c),
                  160'({debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}),
                  160'({rf ? m_ins.pc : 32'd0, rf ? 4'hF : 4'h0, rf ? m_ins.waddr : 5'd0, rf ? wd : 32'd0}));
            if (mem_to_wb_valid && allow) begin
                m_have  = nx.ld_en && !nx.excp && data_ok && !need;
                m_word  = data_rdata;
                m_ins   = nx;
                m_valid = 1'b1;
            end else if (cm) begin
                m_valid = 1'b0;
                m_have  = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
